mmio_uart_fifo_ctrl: RTL

//  Memory-mapped I/O controller between the CPU memory stage and the on-chip uart. Replaces the

---
 rtl/mmio_uart_fifo_ctrl.sv | 120 ++++++++++++
 1 files changed

// File: rtl/mmio_uart_fifo_ctrl.sv
// mmio_uart_fifo_ctrl: MMIO bridge between the CPU memory stage and the uart, with RX/TX FIFOs,
// sticky overflow flags and cycle/instruction counters.
module mmio_uart_fifo_ctrl_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               din,
  output logic [7:0]               head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic          wr, rd;
  assign full  = count == FULL_CNT;
  assign empty = count == '0;
  assign rd    = pop & ~empty;
  // a full FIFO still accepts a write when the head leaves in the same cycle
  assign wr    = push & (~full | rd);
  assign head  = mem[rptr];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr) begin
        mem[wptr] <= din;
        wptr      <= wptr + 1'b1;
      end
      if (rd) rptr <= rptr + 1'b1;
      count <= count + (AW+1)'(wr) - (AW+1)'(rd);
    end
  end
endmodule

module mmio_uart_fifo_ctrl #(
  parameter int          RX_DEPTH  = 8,
  parameter int          TX_DEPTH  = 8,
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        ld_en,
  input  logic        st_en,
  input  logic        inst_retire,
  output logic [31:0] rdata,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);
  localparam int RAW = $clog2(RX_DEPTH);
  localparam int TAW = $clog2(TX_DEPTH);
  logic [RAW:0]  rx_count;
  logic [TAW:0]  tx_count;
  logic [7:0]    rx_head;
  logic          rx_full, rx_empty, tx_full, tx_empty;
  logic          win, ld, st, rx_pop, tx_push, flag_clr, cnt_rst;
  logic          rx_ovf_set, tx_ovf_set, rx_ovf, tx_ovf;
  logic [4:0]    off;
  logic [31:0]   status, rd_next, cycle_cnt, instr_cnt;
  logic          unused_bits;
  assign unused_bits = ^{wdata[31:8], addr[27:5]};
  assign win      = addr[31:28] == BASE_ADDR[31:28];
  assign off      = addr[4:0];
  assign ld       = ld_en & win;
  assign st       = st_en & win;
  assign rx_pop   = ld & (off == 5'h04);
  assign tx_push  = st & (off == 5'h08);
  assign flag_clr = st & (off == 5'h0C);
  assign cnt_rst  = st & (off == 5'h18);
  assign rx_ready = ~rx_full;
  assign tx_valid = ~tx_empty;
  // rx_ovf reports the receiver presenting a byte while the RX FIFO is full
  assign rx_ovf_set = rx_valid & rx_full;
  assign tx_ovf_set = tx_push & tx_full & ~tx_ready;
  mmio_uart_fifo_ctrl_fifo #(.DEPTH(RX_DEPTH)) u_rx (
    .clk(clk), .rst_n(rst_n), .push(rx_valid & ~rx_full), .pop(rx_pop), .din(rx_data),
    .head(rx_head), .count(rx_count), .full(rx_full), .empty(rx_empty)
  );
  mmio_uart_fifo_ctrl_fifo #(.DEPTH(TX_DEPTH)) u_tx (
    .clk(clk), .rst_n(rst_n), .push(tx_push), .pop(tx_ready), .din(wdata[7:0]),
    .head(tx_data), .count(tx_count), .full(tx_full), .empty(tx_empty)
  );
  assign status = {8'(tx_count), 8'(rx_count), 12'b0, tx_ovf, rx_ovf, ~rx_empty, ~tx_full};
  always_comb begin
    rd_next = !ld               ? 32'h0 :
              off == 5'h00      ? status :
              off == 5'h04      ? {24'b0, rx_empty ? 8'h00 : rx_head} :
              off == 5'h10      ? cycle_cnt :
              off == 5'h14      ? instr_cnt : 32'h0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata     <= '0;
      rx_ovf    <= 1'b0;
      tx_ovf    <= 1'b0;
      cycle_cnt <= '0;
      instr_cnt <= '0;
    end else begin
      rdata     <= rd_next;
      rx_ovf    <= rx_ovf_set | (rx_ovf & ~flag_clr);
      tx_ovf    <= tx_ovf_set | (tx_ovf & ~flag_clr);
      cycle_cnt <= cnt_rst ? 32'h0 : cycle_cnt + 32'h1;
      instr_cnt <= cnt_rst ? 32'h0 : instr_cnt + 32'(inst_retire);
    end
  end
endmodule
